// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arbiter_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Quotient returned for a zero divisor; sliced down to the data width
    // at the point of use, so any DATA_WIDTH up to 64 is covered.
    localparam logic [63:0] DIV_BY_ZERO_QUOTIENT = '1;

    // Width of a requester index (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider signals of the divider arbiter, bundled.
interface div_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_dividend;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0]                 rsp_ready;
    logic [DATA_WIDTH-1:0]              rsp_quotient;
    logic [DATA_WIDTH-1:0]              rsp_remainder;
    logic                               rsp_overflow;
    logic                               div_start;
    logic [DATA_WIDTH-1:0]              div_dividend;
    logic [DATA_WIDTH-1:0]              div_divisor;
    logic [DATA_WIDTH-1:0]              div_quotient;
    logic [DATA_WIDTH-1:0]              div_remainder;
    logic                               div_overflow;
    logic                               div_done;

    // Arbiter side
    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder, div_overflow, div_done,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
               div_start, div_dividend, div_divisor
    );

    // Requesters plus divider side
    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
               div_quotient, div_remainder, div_overflow, div_done,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
               div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin winner selection: first requester above last_grant, wrapping.
module rr_pick
    import div_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);
    logic found;
    int   base;

    // Scan positions last_grant+1 .. last_grant+NUM_REQ modulo NUM_REQ
    always_comb begin
        grant = '0;
        found = 1'b0;
        base  = int'(last_grant) + 1;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == (base + k) % NUM_REQ)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider between NUM_REQ requesters with round-robin
// arbitration, divide-by-zero bypass and a WAIT watchdog.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.slave  bus
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      sel_idx;
    logic [DATA_WIDTH-1:0] sel_dividend;
    logic [DATA_WIDTH-1:0] sel_divisor;
    logic [NUM_REQ-1:0]    rsp_valid_c;
    logic                  owner_ack;
    logic [NUM_REQ-1:0]    req_ready_c;
    logic                  div_start_c;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Turn the one-hot grant into an index and the winner's operands
    always_comb begin
        sel_idx      = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                sel_idx      = IDX_W'(j);
                sel_dividend = bus.req_dividend[j];
                sel_divisor  = bus.req_divisor[j];
            end
        end
    end

    // One-hot response valid for the owner; only the owner's ready counts
    always_comb begin
        rsp_valid_c = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (state_q == S_RESP && owner_q == IDX_W'(j)) rsp_valid_c[j] = 1'b1;
        end
        owner_ack = |(rsp_valid_c & bus.rsp_ready);
    end

    // Next-state and control outputs
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        ovf_d        = ovf_q;
        wd_d         = wd_q;
        req_ready_c  = '0;
        div_start_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    req_ready_c = grant;
                    owner_d     = sel_idx;
                    dividend_d  = sel_dividend;
                    divisor_d   = sel_divisor;
                    if (sel_divisor == '0) begin
                        // Zero divisor never reaches the divider
                        quot_d  = DIV_BY_ZERO_QUOTIENT[DATA_WIDTH-1:0];
                        rem_d   = sel_dividend;
                        ovf_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                div_start_c = 1'b1;
                wd_d        = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // done wins over a watchdog expiry in the same cycle
                if (bus.div_done) begin
                    quot_d  = bus.div_quotient;
                    rem_d   = bus.div_remainder;
                    ovf_d   = bus.div_overflow;
                    state_d = S_RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                if (owner_ack) begin
                    last_grant_d = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            ovf_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            ovf_q        <= ovf_d;
            wd_q         <= wd_d;
        end
    end

    // req_ready is combinational from the request vector, so mask it in reset
    assign bus.req_ready     = rst ? '0 : req_ready_c;
    assign bus.div_start     = div_start_c;
    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.rsp_quotient  = quot_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_overflow  = ovf_q & (state_q == S_RESP);
    assign bus.div_dividend  = dividend_q;
    assign bus.div_divisor   = divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: random and directed requests against a
// behavioural model, with a modelled divider of random latency.
module tb_div_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int TO = 64;

    typedef struct {
        int          idx;
        logic [31:0] a, b, q, r;
        logic        ovf;
        bit          dbz;
        bit          hang;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    div_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        cur;
    int          grant_log[$];
    bit          busy = 0;
    int          ref_last = NR - 1;
    int          start_cyc = 0;
    logic        start_prev = 1'b0;
    bit          rsp_seen = 0;
    logic [31:0] held_q;
    logic [34:0] held_rest;
    logic [NR-1:0] acc_vec = '0;
    bit          hang = 0;
    bit          hold_mode = 0;
    bit          rand_ops = 0;
    int          ready_mode = 0;
    int          remaining[NR];
    logic [31:0] fix_a[NR];
    logic [31:0] fix_b[NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Round-robin rule: first valid index after the last owner, wrapping
    function automatic int ref_winner(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    function automatic exp_t ref_result(input int idx, input logic [31:0] a,
                                        input logic [31:0] b, input bit hg, input int c);
        exp_t e;
        e.idx = idx; e.a = a; e.b = b; e.acc_cyc = c;
        e.dbz  = (b == 32'd0);
        e.hang = hg && !e.dbz;
        if (e.dbz) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.ovf = 1'b1;
        end else if (e.hang) begin
            e.q = 32'd0; e.r = 32'd0; e.ovf = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = 32'd0; e.ovf = 1'b1;
        end else begin
            e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Divider: random 1..6 cycle latency, stray done pulses while idle
    bit dbusy = 0;
    int dcnt = 0;
    logic [31:0] dq, dr;
    logic dovf;
    always @(negedge clk) begin
        if (rst) begin
            dbusy = 0; dcnt = 0;
            bus.div_done = 1'b0; bus.div_quotient = '0;
            bus.div_remainder = '0; bus.div_overflow = 1'b0;
        end else if (bus.div_start) begin
            dbusy = 1; dcnt = $urandom_range(1, 6);
            bus.div_done = 1'b0;
            if (bus.div_dividend == 32'h8000_0000 && bus.div_divisor == 32'hFFFF_FFFF) begin
                dq = bus.div_dividend; dr = 32'd0; dovf = 1'b1;
            end else begin
                dq = $signed(bus.div_dividend) / $signed(bus.div_divisor);
                dr = $signed(bus.div_dividend) % $signed(bus.div_divisor);
                dovf = 1'b0;
            end
        end else if (dbusy) begin
            bus.div_done = 1'b0;
            if (!hang) begin
                dcnt--;
                if (dcnt == 0) begin
                    bus.div_done = 1'b1; bus.div_quotient = dq;
                    bus.div_remainder = dr; bus.div_overflow = dovf;
                    dbusy = 0;
                end
            end
        end else begin
            bus.div_done = ($urandom_range(0, 5) == 0);
            bus.div_quotient = $urandom; bus.div_remainder = $urandom;
            bus.div_overflow = 1'(($urandom));
        end
    end

    // Monitor: grants, divider starts and responses against the scoreboard
    always @(negedge clk) begin
        int w;
        cyc++;
        if (rst) begin
            exp_q.delete(); busy = 0; ref_last = NR - 1; rsp_seen = 0;
            start_prev = 1'b0; acc_vec = '0;
        end else begin
            acc_vec = bus.req_valid & bus.req_ready;
            if (bus.req_ready != '0) begin
                w = ref_winner(bus.req_valid, ref_last);
                chk("grant", 64'(bus.req_ready), (w < 0) ? 64'd0 : 64'(NR'(1) << w));
                chk("grant_while_busy", 64'(busy), 64'd0);
                if (w >= 0) begin
                    exp_q.push_back(ref_result(w, bus.req_dividend[w], bus.req_divisor[w], hang, cyc));
                    grant_log.push_back(w);
                    busy = 1;
                end
            end
            if (bus.div_start) begin
                chk("div_start_single", 64'(start_prev), 64'd0);
                if (exp_q.size() > 0) begin
                    chk("div_start_on_dbz", 64'(exp_q[0].dbz), 64'd0);
                    chk("div_operands", {bus.div_dividend, bus.div_divisor}, {exp_q[0].a, exp_q[0].b});
                end else begin
                    chk("div_start_unexpected", 64'(bus.div_start), 64'd0);
                end
                start_cyc = cyc;
            end
            start_prev = bus.div_start;
            if (bus.rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    cur = exp_q[0];
                    chk("rsp_owner", 64'(bus.rsp_valid), 64'(NR'(1) << cur.idx));
                    if (!rsp_seen) begin
                        rsp_seen = 1;
                        held_q = bus.rsp_quotient;
                        held_rest = {bus.rsp_remainder, bus.rsp_overflow, bus.rsp_valid};
                        if (cur.dbz) chk("dbz_latency", 64'(cyc - cur.acc_cyc), 64'd1);
                        else if (cur.hang) chk("timeout_latency", 64'(cyc - start_cyc), 64'(TO + 1));
                    end else begin
                        chk("rsp_stable_q", bus.rsp_quotient, held_q);
                        chk("rsp_stable_r", {bus.rsp_remainder, bus.rsp_overflow, bus.rsp_valid}, held_rest);
                    end
                    if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                        chk("rsp_quotient", bus.rsp_quotient, cur.q);
                        chk("rsp_remainder", bus.rsp_remainder, cur.r);
                        chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(cur.ovf));
                        void'(exp_q.pop_front());
                        ref_last = cur.idx;
                        busy = 0;
                        rsp_seen = 0;
                    end
                end
            end
        end
    end

    task automatic load_ops(input int i);
        logic [31:0] a, b;
        if (rand_ops) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom;
                default: b = 32'($urandom_range(1, 50));
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
        end else begin
            a = fix_a[i]; b = fix_b[i];
        end
        bus.req_dividend[i] = a;
        bus.req_divisor[i]  = b;
    endtask

    // One clock of requester and rsp_ready driving, just after the edge
    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && acc_vec[i]) begin
                remaining[i]--;
                if (remaining[i] <= 0 || !hold_mode) bus.req_valid[i] = 1'b0;
                else load_ops(i);
            end
            if (!bus.req_valid[i] && remaining[i] > 0 && (hold_mode || $urandom_range(0, 2) == 0)) begin
                bus.req_valid[i] = 1'b1;
                load_ops(i);
            end
        end
        case (ready_mode)
            0:       bus.rsp_ready = '1;
            1:       bus.rsp_ready = NR'($urandom);
            default: bus.rsp_ready = NR'(2'b10);
        endcase
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((remaining[0] > 0 || remaining[1] > 0 || busy || exp_q.size() > 0 ||
                    bus.req_valid != '0) && n < budget);
        if (n >= budget) chk({name, "_budget"}, 64'(n), 64'(budget - 1));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_dividend[0] = 32'd9;  bus.req_divisor[0] = 32'd3;
        bus.req_dividend[1] = 32'd8;  bus.req_divisor[1] = 32'd2;
        bus.rsp_ready = '0;
        remaining[0] = 0; remaining[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_div_start", 64'(bus.div_start), 64'd0);
        chk("reset_rsp_overflow", 64'(bus.rsp_overflow), 64'd0);
        chk("reset_rsp_data", {bus.rsp_quotient, bus.rsp_remainder}, 64'd0);
        chk("reset_div_operands", {bus.div_dividend, bus.div_divisor}, 64'd0);
        bus.req_valid = '0;
        @(negedge clk) rst = 1'b0;

        // Both requesters hold 100/7 continuously
        fix_a[0] = 32'd100; fix_b[0] = 32'd7; fix_a[1] = 32'd100; fix_b[1] = 32'd7;
        hold_mode = 1; ready_mode = 0; grant_log.delete();
        remaining[0] = 2; remaining[1] = 2;
        run_until_idle("alternate", 400);
        if (grant_log.size() < 4) chk("alternate_count", 64'(grant_log.size()), 64'd4);
        else for (int i = 0; i < 4; i++) chk("alternate_order", 64'(grant_log[i]), 64'(i % 2));

        // Divide by zero on requester 1
        hold_mode = 0; fix_a[1] = 32'd5; fix_b[1] = 32'd0;
        remaining[1] = 1;
        run_until_idle("div_by_zero", 200);

        // Divider never answers
        hang = 1; fix_a[0] = 32'd9; fix_b[0] = 32'd3; remaining[0] = 1;
        run_until_idle("timeout", 400);
        hang = 0;

        // Owner withholds rsp_ready while the other requester waits
        fix_a[0] = 32'd20; fix_b[0] = 32'd3; fix_a[1] = 32'd21; fix_b[1] = 32'd4;
        ready_mode = 2; remaining[0] = 1;
        n = 0;
        while (bus.rsp_valid[0] !== 1'b1 && n < 200) begin step(); n++; end
        chk("held_rsp_arrives", 64'(bus.rsp_valid), 64'b01);
        remaining[1] = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_no_grant", 64'(bus.req_ready), 64'd0);
            chk("held_rsp_valid", 64'(bus.rsp_valid), 64'b01);
        end
        ready_mode = 0;
        run_until_idle("held", 200);

        // Randomised traffic
        rand_ops = 1; ready_mode = 1; remaining[0] = 25; remaining[1] = 25;
        run_until_idle("random", 20000);
        rand_ops = 0; ready_mode = 0;

        // Asynchronous reset while waiting on the divider
        hang = 1; fix_a[1] = 32'd11; fix_b[1] = 32'd2; remaining[1] = 1;
        n = 0;
        while (bus.div_start !== 1'b1 && n < 200) begin step(); n++; end
        chk("mid_reset_started", 64'(bus.div_start), 64'd1);
        repeat (5) step();
        #1 rst = 1'b1;
        #1;
        chk("mid_reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_reset_div_start", 64'(bus.div_start), 64'd0);
        chk("mid_reset_rsp_overflow", 64'(bus.rsp_overflow), 64'd0);
        chk("mid_reset_rsp_data", {bus.rsp_quotient, bus.rsp_remainder}, 64'd0);
        chk("mid_reset_div_operands", {bus.div_dividend, bus.div_divisor}, 64'd0);
        remaining[0] = 0; remaining[1] = 0; bus.req_valid = '0;
        repeat (2) @(posedge clk);
        hang = 0;
        @(negedge clk) rst = 1'b0;
        grant_log.delete();
        fix_a[0] = 32'd30; fix_b[0] = 32'd4; fix_a[1] = 32'd31; fix_b[1] = 32'd5;
        hold_mode = 1; remaining[0] = 1; remaining[1] = 1;
        run_until_idle("after_reset", 200);
        if (grant_log.size() == 0) chk("first_grant_after_reset_seen", 64'd0, 64'd1);
        else chk("first_grant_after_reset", 64'(grant_log[0]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
